// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller.
// All segment and anode patterns are active-low.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Entry n holds {g,f,e,d,c,b,a} for hex digit n.
  localparam logic [15:0][6:0] HEX7SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [3:0][3:0] digit_bank_t;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-seven-segment decoder.
// The output is active-low {g,f,e,d,c,b,a}.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with a shadow/active digit bank.
// The shadow bank is copied to the active bank only at the frame boundary.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic       blank_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [23:0] CNT_LAST = 24'(SCAN_DIV - 1);
  localparam logic [23:0] CNT_DEAD = 24'(DEAD_CYCLES);

  logic [23:0]  cnt_q;
  logic [1:0]   idx_q;
  logic         pending_q;
  digit_bank_t  shadow_dig_q, active_dig_q;
  logic [3:0]   shadow_dp_q, active_dp_q;
  logic [3:0]   an_q, an_d;
  logic [6:0]   seg_q, seg_d, dec_seg;
  logic         dp_q, dp_d;
  logic         tick, boundary, wr_fire, blank;

  hex7seg_dec u_dec (
    .hex_i (active_dig_q[idx_q]),
    .seg_o (dec_seg)
  );

  // Write handshake: a write lands on any edge where wr_valid && wr_ready.
  // wr_ready is low only while a commit waits for the frame boundary.
  assign wr_ready = !pending_q;
  assign wr_fire  = wr_valid && wr_ready;
  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == 2'd3);

  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd3:    blank = (active_dig_q[3] == 4'd0);
      2'd2:    blank = (active_dig_q[3] == 4'd0) && (active_dig_q[2] == 4'd0);
      2'd1:    blank = (active_dig_q[3] == 4'd0) && (active_dig_q[2] == 4'd0) &&
                       (active_dig_q[1] == 4'd0);
      default: blank = 1'b0;
    endcase
    blank = blank && blank_en;
    an_d  = (cnt_q < CNT_DEAD) ? AN_OFF : ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : dec_seg;
    dp_d  = ~active_dp_q[idx_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      active_dig_q <= '0;
      active_dp_q  <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 24'd1;
      if (tick) idx_q <= idx_q + 2'd1;
      if (wr_fire) begin
        shadow_dig_q[wr_addr] <= wr_data;
        shadow_dp_q[wr_addr]  <= wr_dp;
      end
      // A commit arriving while one is already pending is dropped.
      if (boundary && pending_q) begin
        active_dig_q <= shadow_dig_q;
        active_dp_q  <= shadow_dp_q;
        pending_q    <= 1'b0;
      end else if (commit) begin
        pending_q <= 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a time-indexed reference model predicts every
// output cycle into a queue; a monitor pops and compares each cycle.
module tb_seg_scan_ctrl;

  localparam int SD    = 4;
  localparam int DC    = 1;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic       commit = 1'b0;
  logic       blank_en = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int passed = 0;
  logic [12:0] exp_q[$];

  // Reference model state, indexed by cycles elapsed since reset release.
  int         t = 0;
  logic [3:0] m_shadow[4];
  logic [3:0] m_active[4];
  logic       m_sdp[4];
  logic       m_adp[4];
  logic       m_pending = 1'b0;

  // clock/reset block
  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_dp    (wr_dp),
    .commit   (commit),
    .blank_en (blank_en),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  function automatic logic [6:0] hex_pattern(input logic [3:0] h);
    case (h)
      4'h0: hex_pattern = 7'b1000000;
      4'h1: hex_pattern = 7'b1111001;
      4'h2: hex_pattern = 7'b0100100;
      4'h3: hex_pattern = 7'b0110000;
      4'h4: hex_pattern = 7'b0011001;
      4'h5: hex_pattern = 7'b0010010;
      4'h6: hex_pattern = 7'b0000010;
      4'h7: hex_pattern = 7'b1111000;
      4'h8: hex_pattern = 7'b0000000;
      4'h9: hex_pattern = 7'b0010000;
      4'hA: hex_pattern = 7'b0001000;
      4'hB: hex_pattern = 7'b0000011;
      4'hC: hex_pattern = 7'b1000110;
      4'hD: hex_pattern = 7'b0100001;
      4'hE: hex_pattern = 7'b0000110;
      default: hex_pattern = 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: actual {an,seg,dp,rdy}=%b_%h_%b_%b required %b_%h_%b_%b",
                  name, $time, act[12:9], act[8:2], act[1], act[0],
                  exp[12:9], exp[8:2], exp[1], exp[0]);
  endtask

  // Reference model: slot = t/SD, digit = slot%4, position in slot = t%SD.
  always @(posedge clk) begin
    int         offset;
    int         dig;
    bit         blanked;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (reset) begin
      t = 0;
      m_pending = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 4'd0; m_active[i] = 4'd0; m_sdp[i] = 1'b0; m_adp[i] = 1'b0;
      end
      exp_q.delete();
    end else begin
      offset = t % SD;
      dig    = (t / SD) % 4;
      e_an   = (offset < DC) ? 4'hF : ~(4'b0001 << dig);
      blanked = blank_en && (dig != 0);
      for (int j = dig; j < 4; j++) if (m_active[j] != 4'd0) blanked = 1'b0;
      e_seg = blanked ? 7'h7F : hex_pattern(m_active[dig]);
      e_dp  = ~m_adp[dig];
      if (wr_valid && !m_pending) begin
        m_shadow[wr_addr] = wr_data;
        m_sdp[wr_addr]    = wr_dp;
      end
      if (m_pending && offset == SD - 1 && dig == 3) begin
        for (int i = 0; i < 4; i++) begin
          m_active[i] = m_shadow[i]; m_adp[i] = m_sdp[i];
        end
        m_pending = 1'b0;
      end else if (commit) begin
        m_pending = 1'b1;
      end
      exp_q.push_back({e_an, e_seg, e_dp, ~m_pending});
      t++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scan", {an, seg, dp, wr_ready}, e);
    end
  end

  // driver tasks
  task automatic cyc(input logic v, input logic [1:0] a, input logic [3:0] d,
                     input logic p, input logic c);
    @(negedge clk);
    wr_valid = v; wr_addr = a; wr_data = d; wr_dp = p; commit = c;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic       v, c, p;
    logic [1:0] a;
    logic [3:0] d;
    int         guard;

    #2 reset = 1'b1;
    #2 check("reset_values", {an, seg, dp, wr_ready}, {4'hF, 7'h7F, 1'b1, 1'b1});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(2 * FRAME + 8);

    // Digits 4,3,2,1 on AN0..AN3, then a write attempted while pending.
    cyc(1'b1, 2'd3, 4'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 4'd2, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 4'd3, 1'b1, 1'b0);
    cyc(1'b1, 2'd0, 4'd4, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, 2'd0, 4'd9, 1'b1, 1'b0);
    cyc(1'b1, 2'd1, 4'd9, 1'b0, 1'b0);
    idle(2 * FRAME + 4);
    cyc(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    idle(2 * FRAME + 4);

    // Write and commit in the same cycle.
    cyc(1'b1, 2'd2, 4'd7, 1'b0, 1'b1);
    idle(2 * FRAME + 4);

    // Leading-zero blanking on 0,0,5,0.
    cyc(1'b1, 2'd3, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 4'd5, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 4'd0, 1'b1, 1'b1);
    idle(2 * FRAME + 4);
    blank_en = 1'b0;
    idle(FRAME + 4);
    blank_en = 1'b1;
    idle(FRAME);

    // Random traffic.
    repeat (1500) begin
      v = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 19) == 0);
      p = $urandom_range(0, 1) == 1;
      a = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) blank_en = ~blank_en;
      cyc(v, a, d, p, c);
    end
    blank_en = 1'b1;
    idle(2 * FRAME);

    // Reset mid-slot while a commit is pending.
    cyc(1'b1, 2'd0, 4'd8, 1'b1, 1'b0);
    cyc(1'b1, 2'd3, 4'd6, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    idle(FRAME + 4);
    guard = 0;
    while ((t % FRAME) != 2 && guard < 100) begin
      idle(1);
      guard++;
    end
    cyc(1'b1, 2'd1, 4'd3, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    idle(3);
    #1 reset = 1'b1;
    #1 check("async_reset", {an, seg, dp, wr_ready}, {4'hF, 7'h7F, 1'b1, 1'b1});
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(3 * FRAME);

    @(negedge clk);
    #1 check("queue_drained", 13'(exp_q.size()), 13'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
